unidade_controle_exp7: RTL and testbench

Moore controller for the memory-game datapath: it sequences the address and round counters, the play register and the comparison for each player move, and declares the outcome. It carries an internal play-timeout timer. It sits beside the datapath inside the game top level, receiving `iniciar` and the datapath status signals and driving the counter/register enables plus `pronto`, `ganhou`, `perdeu` and debug outputs.

---
 rtl/unidade_controle_exp7.sv | 143 ++++++++++++++
 tb/tb_unidade_controle_exp7.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_exp7.sv
// unidade_controle_exp7
// Moore controller for the memory game. It walks the datapath through each
// round: it clears the counters, waits for a button press, latches the play,
// compares it with memory and then advances the address or round counter.
// It also declares the outcome: win, wrong play, or timeout while waiting.
// A private timer bounds the time a player may take for each move.
module unidade_controle_exp7 #(
  parameter int TIMEOUT_CICLOS = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       enderecoIgualRodada,
  input  logic       fimR,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraR,
  output logic       contaR,
  output logic       registraR,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  // The timer only has to reach TIMEOUT_CICLOS-1, because the FSM leaves the
  // wait state at that value. It therefore never needs to hold TIMEOUT_CICLOS.
  localparam int TimerW = $clog2(TIMEOUT_CICLOS);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CICLOS - 1);

  // The encodings match the codes shown on the hex debug display.
  typedef enum logic [3:0] {
    sInicial       = 4'h0,
    sPreparacao    = 4'h1,
    sIniciaRodada  = 4'h2,
    sEsperaJogada  = 4'h3,
    sRegistra      = 4'h4,
    sComparacao    = 4'h5,
    sProximaJogada = 4'h6,
    sProximaRodada = 4'h8,
    sFimGanhou     = 4'hA,
    sFimPerdeu     = 4'hB,
    sFimTimeout    = 4'hE
  } estado_t;

  estado_t           estado_q, estado_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              timerExpira;

  assign timerExpira = (timer_q == TimerLast);

  // State and timer registers; reset returns to the idle state at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= sInicial;
      timer_q  <= '0;
    end else begin
      estado_q <= estado_d;
      timer_q  <= timer_d;
    end
  end

  // Next-state logic. A button press takes priority over an expiring timer.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      sInicial:       if (iniciar) estado_d = sPreparacao;
      sPreparacao:    estado_d = sIniciaRodada;
      sIniciaRodada:  estado_d = sEsperaJogada;
      sEsperaJogada: begin
        if (jogada)           estado_d = sRegistra;
        else if (timerExpira) estado_d = sFimTimeout;
        else                  estado_d = sEsperaJogada;
      end
      sRegistra:      estado_d = sComparacao;
      sComparacao: begin
        if (!igual)                    estado_d = sFimPerdeu;
        else if (!enderecoIgualRodada) estado_d = sProximaJogada;
        else if (!fimR)                estado_d = sProximaRodada;
        else                           estado_d = sFimGanhou;
      end
      sProximaJogada: estado_d = sEsperaJogada;
      sProximaRodada: estado_d = sIniciaRodada;
      sFimGanhou,
      sFimPerdeu,
      sFimTimeout:    if (iniciar) estado_d = sPreparacao;
      default:        estado_d = sInicial;
    endcase
  end

  // The timer counts only while the FSM stays in the wait state. It restarts
  // from zero on each new visit, so every move gets the full time allowance.
  always_comb begin
    timer_d = '0;
    if (estado_q == sEsperaJogada && estado_d == sEsperaJogada) begin
      timer_d = timer_q + TimerW'(1);
    end
  end

  // Moore output decode; every output defaults low and depends only on state.
  always_comb begin
    zeraE      = 1'b0;
    contaE     = 1'b0;
    zeraR      = 1'b0;
    contaR     = 1'b0;
    registraR  = 1'b0;
    pronto     = 1'b0;
    ganhou     = 1'b0;
    perdeu     = 1'b0;
    db_timeout = 1'b0;
    case (estado_q)
      sPreparacao: begin
        zeraE = 1'b1;
        zeraR = 1'b1;
      end
      sIniciaRodada:  zeraE     = 1'b1;
      sRegistra:      registraR = 1'b1;
      sProximaJogada: contaE    = 1'b1;
      sProximaRodada: contaR    = 1'b1;
      sFimGanhou: begin
        pronto = 1'b1;
        ganhou = 1'b1;
      end
      sFimPerdeu: begin
        pronto = 1'b1;
        perdeu = 1'b1;
      end
      sFimTimeout: begin
        pronto     = 1'b1;
        perdeu     = 1'b1;
        db_timeout = 1'b1;
      end
      default: ;
    endcase
  end

  // The raw state code drives the hex display.
  assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle_exp7.sv
// tb_unidade_controle_exp7
// Scoreboard bench for the memory-game controller. A stimulus process drives
// the inputs and advances a behavioural game model at every rising edge. It
// queues the expected display code and outputs for the following falling edge.
// A separate monitor pops and compares one entry at each falling edge.
module tb_unidade_controle_exp7;

  localparam int TO = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic       jogada = 1'b0;
  logic       igual = 1'b0;
  logic       enderecoIgualRodada = 1'b0;
  logic       fimR = 1'b0;
  logic       zeraE, contaE, zeraR, contaR, registraR;
  logic       pronto, ganhou, perdeu, db_timeout;
  logic [3:0] db_estado;

  typedef struct {
    logic [3:0] code;
    logic [8:0] outs;
  } exp_t;

  exp_t sbq[$];

  int vectorsApplied = 0;
  int miscompares    = 0;

  // Game model: the current state code, a count of rising edges, and the
  // edge at which the model last entered the wait-for-move state.
  int mCode     = 0;
  int cycleNo   = 0;
  int entryEdge = 0;

  unidade_controle_exp7 #(.TIMEOUT_CICLOS(TO)) dut (
    .clock               (clock),
    .reset               (reset),
    .iniciar             (iniciar),
    .jogada              (jogada),
    .igual               (igual),
    .enderecoIgualRodada (enderecoIgualRodada),
    .fimR                (fimR),
    .zeraE               (zeraE),
    .contaE              (contaE),
    .zeraR               (zeraR),
    .contaR              (contaR),
    .registraR           (registraR),
    .pronto              (pronto),
    .ganhou              (ganhou),
    .perdeu              (perdeu),
    .db_timeout          (db_timeout),
    .db_estado           (db_estado)
  );

  // 10-time-unit clock period.
  always #5 clock = ~clock;

  // Expected outputs for each display code, packed in this order:
  // {zeraE, contaE, zeraR, contaR, registraR, pronto, ganhou, perdeu, db_timeout}.
  function automatic logic [8:0] expOuts(input int code);
    case (code)
      1:       return 9'b101000000;
      2:       return 9'b100000000;
      4:       return 9'b000010000;
      6:       return 9'b010000000;
      8:       return 9'b000100000;
      10:      return 9'b000001100;
      11:      return 9'b000001010;
      14:      return 9'b000001011;
      default: return 9'b000000000;
    endcase
  endfunction

  // Apply the game rules for one rising edge, using the inputs present at it.
  task automatic modelStep();
    int nxt;
    cycleNo++;
    nxt = mCode;
    if (reset) begin
      nxt = 0;
    end else begin
      case (mCode)
        0:  if (iniciar) nxt = 1;
        1:  nxt = 2;
        2:  nxt = 3;
        3: begin
          if (jogada)                       nxt = 4;
          else if (cycleNo - entryEdge == TO) nxt = 14;
        end
        4:  nxt = 5;
        5: begin
          if (!igual)                    nxt = 11;
          else if (!enderecoIgualRodada) nxt = 6;
          else if (!fimR)                nxt = 8;
          else                           nxt = 10;
        end
        6:  nxt = 3;
        8:  nxt = 2;
        10, 11, 14: if (iniciar) nxt = 1;
        default: nxt = 0;
      endcase
    end
    if (nxt == 3 && mCode != 3) entryEdge = cycleNo;
    mCode = nxt;
  endtask

  task automatic pushExpected();
    exp_t e;
    e.code = 4'(mCode);
    e.outs = expOuts(mCode);
    sbq.push_back(e);
  endtask

  // Drive one cycle of inputs, let the edge happen, and queue the expectation.
  task automatic applyStimulus(input logic ini, input logic jog, input logic ig,
                               input logic eq, input logic fr);
    iniciar             = ini;
    jogada              = jog;
    igual               = ig;
    enderecoIgualRodada = eq;
    fimR                = fr;
    @(posedge clock);
    modelStep();
    pushExpected();
    #1;
  endtask

  // Raise reset midway between edges; outputs must clear before the next edge.
  task automatic applyResetMidCycle();
    iniciar = 1'b0;
    jogada  = 1'b0;
    @(posedge clock);
    modelStep();
    mCode = 0;
    pushExpected();
    #3 reset = 1'b1;
    @(posedge clock);
    modelStep();
    pushExpected();
    #1 reset = 1'b0;
  endtask

  // One move: a press, then three quiet cycles that cover registra,
  // comparacao and the state that follows.
  task automatic play(input logic ig, input logic eq, input logic fr);
    applyStimulus(1'b0, 1'b1, ig, eq, fr);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, ig, eq, fr);
  endtask

  task automatic checkOutput();
    exp_t       e;
    logic [8:0] got;
    if (sbq.size() == 0) return;
    e   = sbq.pop_front();
    got = {zeraE, contaE, zeraR, contaR, registraR, pronto, ganhou, perdeu, db_timeout};
    vectorsApplied++;
    if (got !== e.outs || db_estado !== e.code) begin
      miscompares++;
      $display("[TB] FAIL state/outputs at t=%0t: got db_estado=%h outs=%b, expected db_estado=%h outs=%b",
               $time, db_estado, got, e.code, e.outs);
    end
  endtask

  // Monitor: sample away from the rising edge.
  always @(negedge clock) checkOutput();

  initial begin
    int jogMode;
    logic jog, ini;

    // Power-on reset, then 10 idle cycles.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Start, then reset while waiting for a move.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyResetMidCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Win: round 1 advances the round, round 2 has two moves and ends the game.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    play(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    play(1'b1, 1'b0, 1'b0);
    play(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Restart with iniciar held, then lose on move 2 of round 2.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    play(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    play(1'b1, 1'b0, 1'b0);
    play(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Restart from fim_perdeu with iniciar held, then time out.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 22; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Press exactly at the last timer value, then press during comparacao
    // and during proxima_jogada.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < TO - 1; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Random play. The press rate changes every 50 cycles so that both
    // timeouts and long games occur.
    jogMode = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 50 == 0) jogMode = $urandom_range(0, 2);
      case (jogMode)
        0:       jog = 1'b0;
        1:       jog = ($urandom_range(0, 2) == 0);
        default: jog = ($urandom_range(0, 9) == 0);
      endcase
      ini = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 499) == 0) begin
        applyResetMidCycle();
      end else begin
        applyStimulus(ini, jog, ($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      end
    end

    @(negedge clock);
    #1;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
